// File: rtl/hazard_scoreboard_unit.sv
// Decode-side hazard unit: shift-register scoreboard of in-flight destinations,
// per-source forwarding select / stall request, and a saturating stall counter.
module hazard_scoreboard_unit #(
    parameter int unsigned       REG_AW     = 3,
    parameter int unsigned       OP_W       = 4,
    parameter int unsigned       PIPE_DEPTH = 3,
    parameter logic [OP_W-1:0]   LOAD_OP    = OP_W'(4'b0100),
    parameter int unsigned       LOAD_READY = 2,
    parameter int unsigned       FWD_EN     = 1,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dec_valid,
    input  logic [OP_W-1:0]                   dec_op,
    input  logic [REG_AW-1:0]                 dec_src1,
    input  logic                              dec_src1_used,
    input  logic [REG_AW-1:0]                 dec_src2,
    input  logic                              dec_src2_used,
    input  logic [REG_AW-1:0]                 dec_dest,
    input  logic                              dec_writes,
    input  logic                              flush,
    output logic                              should_stall,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_sel1,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_sel2,
    output logic [CNT_W-1:0]                  stall_count
);

    localparam int unsigned SEL_W = $clog2(PIPE_DEPTH + 1);

    logic                r_valid   [PIPE_DEPTH];
    logic [REG_AW-1:0]   r_dest    [PIPE_DEPTH];
    logic                r_is_load [PIPE_DEPTH];
    logic [CNT_W-1:0]    r_stall_count;

    logic [REG_AW-1:0]   w_src    [2];
    logic                w_used   [2];
    logic                w_hazard [2];
    logic [SEL_W-1:0]    w_sel    [2];
    logic                w_stall;
    logic                w_push;

    assign w_src[0]  = dec_src1;
    assign w_src[1]  = dec_src2;
    assign w_used[0] = dec_src1_used;
    assign w_used[1] = dec_src2_used;

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic             w_hit;
        logic [SEL_W-1:0] w_idx;
        logic             w_ld;
        logic             w_early;

        // Scan oldest to youngest so the youngest (lowest index) match is kept last.
        always_comb begin
            w_hit   = 1'b0;
            w_idx   = '0;
            w_ld    = 1'b0;
            w_early = 1'b0;
            for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
                if (dec_valid && w_used[s] && r_valid[k] && (r_dest[k] == w_src[s])) begin
                    w_hit   = 1'b1;
                    w_idx   = SEL_W'(k);
                    w_ld    = r_is_load[k];
                    w_early = (k < int'(LOAD_READY));
                end
            end
        end

        // Without forwarding any dependency must wait for write-back.
        assign w_hazard[s] = (FWD_EN != 0) ? (w_hit & w_ld & w_early) : w_hit;
        assign w_sel[s]    = ((FWD_EN != 0) && w_hit && !w_hazard[s]) ? (w_idx + SEL_W'(1))
                                                                       : '0;
    end

    assign w_stall = (w_hazard[0] | w_hazard[1]) & ~flush;
    assign w_push  = dec_valid & dec_writes & ~w_stall & ~flush;

    assign should_stall = w_stall;
    assign fwd_sel1     = w_sel[0];
    assign fwd_sel2     = w_sel[1];
    assign stall_count  = r_stall_count;

    // Scoreboard always advances; entry 0 receives the decode instruction or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                r_valid[k]   <= 1'b0;
                r_dest[k]    <= '0;
                r_is_load[k] <= 1'b0;
            end
            r_stall_count <= '0;
        end else begin
            for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_dest[k]    <= r_dest[k-1];
                r_is_load[k] <= r_is_load[k-1];
            end
            r_valid[0]   <= w_push;
            r_dest[0]    <= dec_dest;
            r_is_load[0] <= (dec_op == LOAD_OP);
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench: a forwarding build (defaults) and a no-forwarding build with a
// 2-bit stall counter, driven by directed vectors with hand-computed expectations.
module tb_hazard_scoreboard_unit;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] LW  = 4'b0100;

    logic clk;
    logic rst;

    logic       a_valid, a_s1u, a_s2u, a_wr, a_flush;
    logic [3:0] a_op;
    logic [2:0] a_s1, a_s2, a_dest;
    logic       a_stall;
    logic [1:0] a_sel1, a_sel2;
    logic [15:0] a_cnt;

    logic       b_valid, b_s1u, b_s2u, b_wr, b_flush;
    logic [3:0] b_op;
    logic [2:0] b_s1, b_s2, b_dest;
    logic       b_stall;
    logic [1:0] b_sel1, b_sel2;
    logic [1:0] b_cnt;

    hazard_scoreboard_unit dut_a (
        .clk(clk), .rst(rst),
        .dec_valid(a_valid), .dec_op(a_op),
        .dec_src1(a_s1), .dec_src1_used(a_s1u),
        .dec_src2(a_s2), .dec_src2_used(a_s2u),
        .dec_dest(a_dest), .dec_writes(a_wr), .flush(a_flush),
        .should_stall(a_stall), .fwd_sel1(a_sel1), .fwd_sel2(a_sel2),
        .stall_count(a_cnt)
    );

    hazard_scoreboard_unit #(.FWD_EN(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .dec_valid(b_valid), .dec_op(b_op),
        .dec_src1(b_s1), .dec_src1_used(b_s1u),
        .dec_src2(b_s2), .dec_src2_used(b_s2u),
        .dec_dest(b_dest), .dec_writes(b_wr), .flush(b_flush),
        .should_stall(b_stall), .fwd_sel1(b_sel1), .fwd_sel2(b_sel2),
        .stall_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         unit;
        string      name;
        logic       stall;
        logic [1:0] sel1;
        logic [1:0] sel2;
        logic       chk_cnt;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    exp_t       m_e;
    logic       m_stall;
    logic [1:0] m_sel1, m_sel2;
    int         m_cnt;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e = q.pop_front();
            if (m_e.unit == 0) begin
                m_stall = a_stall; m_sel1 = a_sel1; m_sel2 = a_sel2; m_cnt = int'(a_cnt);
            end else begin
                m_stall = b_stall; m_sel1 = b_sel1; m_sel2 = b_sel2; m_cnt = int'(b_cnt);
            end
            checks++;
            if (m_stall !== m_e.stall) begin
                failures++;
                $display("FAIL %s should_stall got=%0b exp=%0b", m_e.name, m_stall, m_e.stall);
            end
            checks++;
            if (m_sel1 !== m_e.sel1) begin
                failures++;
                $display("FAIL %s fwd_sel1 got=%0d exp=%0d", m_e.name, m_sel1, m_e.sel1);
            end
            checks++;
            if (m_sel2 !== m_e.sel2) begin
                failures++;
                $display("FAIL %s fwd_sel2 got=%0d exp=%0d", m_e.name, m_sel2, m_e.sel2);
            end
            if (m_e.chk_cnt) begin
                checks++;
                if (m_cnt != m_e.cnt) begin
                    failures++;
                    $display("FAIL %s stall_count got=%0d exp=%0d", m_e.name, m_cnt, m_e.cnt);
                end
            end
        end
    end

    task automatic step(input int unit, input logic v, input logic [3:0] op,
                        input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2,
                        input logic [2:0] d, input logic w, input logic fl,
                        input logic es, input logic [1:0] e1, input logic [1:0] e2,
                        input logic cc, input int ec, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        a_valid = 1'b0; a_op = ADD; a_s1 = '0; a_s1u = 1'b0; a_s2 = '0; a_s2u = 1'b0;
        a_dest = '0; a_wr = 1'b0; a_flush = 1'b0;
        b_valid = 1'b0; b_op = ADD; b_s1 = '0; b_s1u = 1'b0; b_s2 = '0; b_s2u = 1'b0;
        b_dest = '0; b_wr = 1'b0; b_flush = 1'b0;
        if (unit == 0) begin
            a_valid = v; a_op = op; a_s1 = s1; a_s1u = u1; a_s2 = s2; a_s2u = u2;
            a_dest = d; a_wr = w; a_flush = fl;
        end else begin
            b_valid = v; b_op = op; b_s1 = s1; b_s1u = u1; b_s2 = s2; b_s2u = u2;
            b_dest = d; b_wr = w; b_flush = fl;
        end
        e.unit = unit; e.name = nm; e.stall = es; e.sel1 = e1; e.sel2 = e2;
        e.chk_cnt = cc; e.cnt = ec;
        q.push_back(e);
    endtask

    task automatic idle(input int unit, input int n);
        for (int i = 0; i < n; i++)
            step(unit, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        a_valid = 1'b1; a_op = LW; a_s1 = 3'd1; a_s1u = 1'b1; a_s2 = 3'd1; a_s2u = 1'b1;
        a_dest = 3'd1; a_wr = 1'b1; a_flush = 1'b0;
        b_valid = 1'b1; b_op = ADD; b_s1 = 3'd1; b_s1u = 1'b1; b_s2 = 3'd1; b_s2u = 1'b1;
        b_dest = 3'd1; b_wr = 1'b1; b_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        e.unit = 0; e.name = "reset_a"; e.stall = 0; e.sel1 = 0; e.sel2 = 0;
        e.chk_cnt = 1; e.cnt = 0;
        q.push_back(e);
        e.unit = 1; e.name = "reset_b";
        @(posedge clk);
        #1;
        q.push_back(e);

        // ALU chain on R3
        step(0, 1, ADD, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, "alu_wr_r3");
        step(0, 1, ADD, 3, 1, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0, "alu_rd_ex");
        step(0, 1, ADD, 3, 1, 0, 0, 7, 0, 0, 0, 2, 0, 0, 0, "alu_rd_mem");
        idle(0, 3);

        // Load-use on R5: two stall cycles then forward from entry 2
        step(0, 1, LW,  0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, "lw_r5");
        step(0, 1, ADD, 0, 0, 5, 1, 6, 1, 0, 1, 0, 0, 1, 0, "lu_stall1");
        step(0, 1, ADD, 0, 0, 5, 1, 6, 1, 0, 1, 0, 0, 1, 1, "lu_stall2");
        step(0, 1, ADD, 0, 0, 5, 1, 6, 1, 0, 0, 0, 3, 1, 2, "lu_fwd");
        idle(0, 3);

        // Youngest writer wins
        step(0, 1, ADD, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, "yw_wr1");
        step(0, 1, ADD, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, "yw_wr2");
        step(0, 1, ADD, 2, 1, 2, 1, 0, 0, 0, 0, 1, 1, 0, 0, "yw_rd");
        idle(0, 3);

        // Same instruction reads and writes R7: no self-hazard
        step(0, 1, LW,  7, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0, 0, "self_dep");
        idle(0, 3);

        // Flush on the load-dependent cycle
        step(0, 1, LW,  0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, "fl_lw_r4");
        step(0, 1, ADD, 4, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 2, "fl_kill");
        step(0, 1, ADD, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "fl_e0_empty");
        step(0, 1, ADD, 0, 0, 4, 1, 0, 0, 0, 0, 0, 3, 1, 2, "fl_rd_r4");
        idle(0, 3);

        // No-forwarding build: R1 dependency stalls until it leaves the scoreboard
        step(1, 1, ADD, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, "nf_wr_r1");
        step(1, 1, ADD, 1, 1, 0, 0, 2, 1, 0, 1, 0, 0, 1, 0, "nf_stall1");
        step(1, 1, ADD, 1, 1, 0, 0, 2, 1, 0, 1, 0, 0, 1, 1, "nf_stall2");
        step(1, 1, ADD, 1, 1, 0, 0, 2, 1, 0, 1, 0, 0, 1, 2, "nf_stall3");
        step(1, 1, ADD, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 3, "nf_go");
        // Counter is now at max; further stalls must not wrap
        step(1, 1, ADD, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, "sat_stall1");
        step(1, 1, ADD, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, "sat_stall2");
        step(1, 1, ADD, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, "sat_stall3");
        step(1, 1, ADD, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, "sat_hold");
        step(0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, "a_cnt_final");

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
